// File: rtl/pcie_pkg.sv
// Shared PCIe TX definitions: bus widths, source indices, arbiter state and beat struct.
// Width macros may be overridden on the command line before this file is compiled.
`ifndef PCIE_DATA_WIDTH
`define PCIE_DATA_WIDTH 64
`endif
`ifndef PCIE_DATA_KW
`define PCIE_DATA_KW 8
`endif
`ifndef PCIE_TUSER_W
`define PCIE_TUSER_W 8
`endif
`ifndef XIL_TX_USER_W
`define XIL_TX_USER_W 4
`endif

package pcie_pkg;

    localparam int SRC_SD  = 0;
    localparam int SRC_RC  = 1;
    localparam int SRC_RG  = 2;
    localparam int NUM_SRC = 3;

    localparam int DATA_W  = `PCIE_DATA_WIDTH;
    localparam int KEEP_W  = `PCIE_DATA_KW;
    localparam int TUSER_W = `PCIE_TUSER_W;
    localparam int XUSER_W = `XIL_TX_USER_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [KEEP_W-1:0]  keep;
        logic               eop;
        logic [XUSER_W-1:0] tuser;
    } tx_beat_t;

    // Round-robin pick: first requester found scanning from last+1 modulo NUM_SRC.
    function automatic logic [1:0] rr_pick(input logic [NUM_SRC-1:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = last;
        idx   = last;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (idx == 2'(NUM_SRC - 1)) ? 2'd0 : idx + 2'd1;
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// One-deep valid/ready output register; holds its beat stable while the sink stalls.
module axis_pipe_reg
    import pcie_pkg::*;
(
    input  logic     clk,
    input  logic     rst_nm,
    input  logic     i_valid,
    input  tx_beat_t i_beat,
    output logic     o_ready,
    output logic     o_valid,
    output tx_beat_t o_beat,
    input  logic     i_ready
);

    logic     r_valid;
    tx_beat_t r_beat;

    assign o_ready = !r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_beat  = r_beat;

    always_ff @(posedge clk) begin
        if (!rst_nm) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_beat  <= i_beat;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/egress_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the PCIe TX AXIS port between sd, rc and rg,
// with per-source packet counters and sticky framing-error flags.
module egress_tx_arbiter
    import pcie_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_nm,
    input  logic                          sd_s_axis_tx_tvalid,
    output logic                          sd_s_axis_tx_tready,
    input  logic [`PCIE_DATA_WIDTH-1:0]   sd_s_axis_tx_tdata,
    input  logic [`PCIE_DATA_KW-1:0]      sd_s_axis_tx_tkeep,
    input  logic                          sd_s_axis_tx_sop,
    input  logic                          sd_s_axis_tx_eop,
    input  logic [`PCIE_TUSER_W-1:0]      sd_s_axis_tx_tuser,
    input  logic                          rc_s_axis_tx_tvalid,
    output logic                          rc_s_axis_tx_tready,
    input  logic [`PCIE_DATA_WIDTH-1:0]   rc_s_axis_tx_tdata,
    input  logic [`PCIE_DATA_KW-1:0]      rc_s_axis_tx_tkeep,
    input  logic                          rc_s_axis_tx_sop,
    input  logic                          rc_s_axis_tx_eop,
    input  logic [`PCIE_TUSER_W-1:0]      rc_s_axis_tx_tuser,
    input  logic                          rg_s_axis_tx_tvalid,
    output logic                          rg_s_axis_tx_tready,
    input  logic [`PCIE_DATA_WIDTH-1:0]   rg_s_axis_tx_tdata,
    input  logic [`PCIE_DATA_KW-1:0]      rg_s_axis_tx_tkeep,
    input  logic                          rg_s_axis_tx_sop,
    input  logic                          rg_s_axis_tx_eop,
    input  logic [`PCIE_TUSER_W-1:0]      rg_s_axis_tx_tuser,
    input  logic                          m_axis_tx_tready,
    output logic                          m_axis_tx_tvalid,
    output logic [`PCIE_DATA_WIDTH-1:0]   m_axis_tx_tdata,
    output logic [`PCIE_DATA_KW-1:0]      m_axis_tx_tkeep,
    output logic                          m_axis_tx_tlast,
    output logic [`XIL_TX_USER_W-1:0]     m_axis_tx_tuser,
    output logic [CNT_W-1:0]              sd_pkt_cnt,
    output logic [CNT_W-1:0]              rc_pkt_cnt,
    output logic [CNT_W-1:0]              rg_pkt_cnt,
    output logic [2:0]                    err_nosop,
    output logic [2:0]                    err_midsop,
    input  logic                          err_clr
);

    logic [NUM_SRC-1:0] w_tvalid;
    logic [NUM_SRC-1:0] w_sop;
    tx_beat_t           w_beat [NUM_SRC];

    assign w_tvalid = {rg_s_axis_tx_tvalid, rc_s_axis_tx_tvalid, sd_s_axis_tx_tvalid};
    assign w_sop    = {rg_s_axis_tx_sop, rc_s_axis_tx_sop, sd_s_axis_tx_sop};
    assign w_beat[SRC_SD] = {sd_s_axis_tx_tdata, sd_s_axis_tx_tkeep, sd_s_axis_tx_eop,
                             sd_s_axis_tx_tuser[XUSER_W-1:0]};
    assign w_beat[SRC_RC] = {rc_s_axis_tx_tdata, rc_s_axis_tx_tkeep, rc_s_axis_tx_eop,
                             rc_s_axis_tx_tuser[XUSER_W-1:0]};
    assign w_beat[SRC_RG] = {rg_s_axis_tx_tdata, rg_s_axis_tx_tkeep, rg_s_axis_tx_eop,
                             rg_s_axis_tx_tuser[XUSER_W-1:0]};

    generate
        if (TUSER_W > XUSER_W) begin : g_tuser_hi
            logic w_unused_tuser_hi;
            assign w_unused_tuser_hi = ^{sd_s_axis_tx_tuser[TUSER_W-1:XUSER_W],
                                         rc_s_axis_tx_tuser[TUSER_W-1:XUSER_W],
                                         rg_s_axis_tx_tuser[TUSER_W-1:XUSER_W]};
        end
    endgenerate

    arb_state_e         r_state, w_state_next;
    logic [1:0]         r_grant, w_grant_next;
    logic [1:0]         r_last, w_last_next;
    logic               r_first;
    logic               w_pipe_ready, w_in_valid, w_accept;
    logic [NUM_SRC-1:0] w_req, w_flush, w_midsop, w_tready;
    tx_beat_t           w_sel_beat;
    tx_beat_t           w_out_beat;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_flush      = '0;
        w_midsop     = '0;
        w_tready     = '0;
        w_in_valid   = 1'b0;
        w_accept     = 1'b0;
        w_req        = w_tvalid & w_sop;
        w_sel_beat   = w_beat[r_grant];
        case (r_state)
            IDLE: begin
                w_flush  = w_tvalid & ~w_sop;
                w_tready = w_flush;
                if (|w_req) begin
                    w_grant_next = rr_pick(w_req, r_last);
                    w_state_next = ARB;
                end
            end
            ARB: w_state_next = BUSY;
            BUSY: begin
                w_in_valid        = w_tvalid[r_grant];
                w_tready[r_grant] = w_pipe_ready;
                w_accept          = w_in_valid & w_pipe_ready;
                if (w_accept) begin
                    if (w_sop[r_grant] && !r_first) w_midsop[r_grant] = 1'b1;
                    if (w_sel_beat.eop) begin
                        w_last_next  = r_grant;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // tready is combinational, so gate it to keep every output quiet while reset is held.
    assign sd_s_axis_tx_tready = w_tready[SRC_SD] & rst_nm;
    assign rc_s_axis_tx_tready = w_tready[SRC_RC] & rst_nm;
    assign rg_s_axis_tx_tready = w_tready[SRC_RG] & rst_nm;

    always_ff @(posedge clk) begin
        if (!rst_nm) begin
            r_state <= IDLE;
            r_grant <= 2'd0;
            r_last  <= 2'(SRC_RG);
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
            if (r_state == ARB)  r_first <= 1'b1;
            else if (w_accept)   r_first <= 1'b0;
        end
    end

    axis_pipe_reg u_pipe (
        .clk     (clk),
        .rst_nm  (rst_nm),
        .i_valid (w_in_valid),
        .i_beat  (w_sel_beat),
        .o_ready (w_pipe_ready),
        .o_valid (m_axis_tx_tvalid),
        .o_beat  (w_out_beat),
        .i_ready (m_axis_tx_tready)
    );

    assign m_axis_tx_tdata = w_out_beat.data;
    assign m_axis_tx_tkeep = w_out_beat.keep;
    assign m_axis_tx_tlast = w_out_beat.eop;
    assign m_axis_tx_tuser = w_out_beat.tuser;

    logic [CNT_W-1:0]   r_pkt_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] r_err_nosop, r_err_midsop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            always_ff @(posedge clk) begin
                if (!rst_nm) begin
                    r_pkt_cnt[gi]    <= '0;
                    r_err_nosop[gi]  <= 1'b0;
                    r_err_midsop[gi] <= 1'b0;
                end else begin
                    if (w_accept && (r_grant == 2'(gi)) && w_sel_beat.eop)
                        r_pkt_cnt[gi] <= r_pkt_cnt[gi] + 1'b1;
                    if (err_clr) begin
                        r_err_nosop[gi]  <= 1'b0;
                        r_err_midsop[gi] <= 1'b0;
                    end else begin
                        if (w_flush[gi])  r_err_nosop[gi]  <= 1'b1;
                        if (w_midsop[gi]) r_err_midsop[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign sd_pkt_cnt = r_pkt_cnt[SRC_SD];
    assign rc_pkt_cnt = r_pkt_cnt[SRC_RC];
    assign rg_pkt_cnt = r_pkt_cnt[SRC_RG];
    assign err_nosop  = r_err_nosop;
    assign err_midsop = r_err_midsop;

endmodule

// File: tb/tb_egress_tx_arbiter.sv
// Directed bench for egress_tx_arbiter: fairness, latency, backpressure, error flags,
// reset mid-packet and counter wrap (second instance with CNT_W=2).
`timescale 1ns/1ps
module tb_egress_tx_arbiter;
    import pcie_pkg::*;

    localparam int DW = `PCIE_DATA_WIDTH;
    localparam int KW = `PCIE_DATA_KW;
    localparam int TW = `PCIE_TUSER_W;
    localparam int XW = `XIL_TX_USER_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_nm, m_tready, err_clr;
    logic          s_tvalid [3];
    logic          s_sop    [3];
    logic          s_eop    [3];
    logic [DW-1:0] s_tdata  [3];
    logic [KW-1:0] s_tkeep  [3];
    logic [TW-1:0] s_tuser  [3];

    logic [2:0]    tr;
    logic          m_tvalid, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [XW-1:0] m_tuser;
    logic [15:0]   sd_cnt, rc_cnt, rg_cnt;
    logic [2:0]    err_nosop, err_midsop;

    logic [2:0]    u2_unused_tr;
    logic          u2_unused_tvalid, u2_unused_tlast;
    logic [DW-1:0] u2_unused_tdata;
    logic [KW-1:0] u2_unused_tkeep;
    logic [XW-1:0] u2_unused_tuser;
    logic [1:0]    u2_unused_sd_cnt, u2_rc_cnt, u2_unused_rg_cnt;
    logic [2:0]    u2_unused_nosop, u2_unused_midsop;

    egress_tx_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_nm(rst_nm),
        .sd_s_axis_tx_tvalid(s_tvalid[0]), .sd_s_axis_tx_tready(tr[0]), .sd_s_axis_tx_tdata(s_tdata[0]),
        .sd_s_axis_tx_tkeep(s_tkeep[0]), .sd_s_axis_tx_sop(s_sop[0]), .sd_s_axis_tx_eop(s_eop[0]),
        .sd_s_axis_tx_tuser(s_tuser[0]),
        .rc_s_axis_tx_tvalid(s_tvalid[1]), .rc_s_axis_tx_tready(tr[1]), .rc_s_axis_tx_tdata(s_tdata[1]),
        .rc_s_axis_tx_tkeep(s_tkeep[1]), .rc_s_axis_tx_sop(s_sop[1]), .rc_s_axis_tx_eop(s_eop[1]),
        .rc_s_axis_tx_tuser(s_tuser[1]),
        .rg_s_axis_tx_tvalid(s_tvalid[2]), .rg_s_axis_tx_tready(tr[2]), .rg_s_axis_tx_tdata(s_tdata[2]),
        .rg_s_axis_tx_tkeep(s_tkeep[2]), .rg_s_axis_tx_sop(s_sop[2]), .rg_s_axis_tx_eop(s_eop[2]),
        .rg_s_axis_tx_tuser(s_tuser[2]),
        .m_axis_tx_tready(m_tready), .m_axis_tx_tvalid(m_tvalid), .m_axis_tx_tdata(m_tdata),
        .m_axis_tx_tkeep(m_tkeep), .m_axis_tx_tlast(m_tlast), .m_axis_tx_tuser(m_tuser),
        .sd_pkt_cnt(sd_cnt), .rc_pkt_cnt(rc_cnt), .rg_pkt_cnt(rg_cnt),
        .err_nosop(err_nosop), .err_midsop(err_midsop), .err_clr(err_clr)
    );

    egress_tx_arbiter #(.CNT_W(2)) dut_wrap (
        .clk(clk), .rst_nm(rst_nm),
        .sd_s_axis_tx_tvalid(s_tvalid[0]), .sd_s_axis_tx_tready(u2_unused_tr[0]), .sd_s_axis_tx_tdata(s_tdata[0]),
        .sd_s_axis_tx_tkeep(s_tkeep[0]), .sd_s_axis_tx_sop(s_sop[0]), .sd_s_axis_tx_eop(s_eop[0]),
        .sd_s_axis_tx_tuser(s_tuser[0]),
        .rc_s_axis_tx_tvalid(s_tvalid[1]), .rc_s_axis_tx_tready(u2_unused_tr[1]), .rc_s_axis_tx_tdata(s_tdata[1]),
        .rc_s_axis_tx_tkeep(s_tkeep[1]), .rc_s_axis_tx_sop(s_sop[1]), .rc_s_axis_tx_eop(s_eop[1]),
        .rc_s_axis_tx_tuser(s_tuser[1]),
        .rg_s_axis_tx_tvalid(s_tvalid[2]), .rg_s_axis_tx_tready(u2_unused_tr[2]), .rg_s_axis_tx_tdata(s_tdata[2]),
        .rg_s_axis_tx_tkeep(s_tkeep[2]), .rg_s_axis_tx_sop(s_sop[2]), .rg_s_axis_tx_eop(s_eop[2]),
        .rg_s_axis_tx_tuser(s_tuser[2]),
        .m_axis_tx_tready(m_tready), .m_axis_tx_tvalid(u2_unused_tvalid), .m_axis_tx_tdata(u2_unused_tdata),
        .m_axis_tx_tkeep(u2_unused_tkeep), .m_axis_tx_tlast(u2_unused_tlast), .m_axis_tx_tuser(u2_unused_tuser),
        .sd_pkt_cnt(u2_unused_sd_cnt), .rc_pkt_cnt(u2_rc_cnt), .rg_pkt_cnt(u2_unused_rg_cnt),
        .err_nosop(u2_unused_nosop), .err_midsop(u2_unused_midsop), .err_clr(err_clr)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture: a beat transfers at the next posedge when valid & ready at the negedge.
    logic [DW-1:0] cap_data [$];
    logic          cap_last [$];
    logic [KW-1:0] cap_keep [$];
    logic [XW-1:0] cap_user [$];
    int            cap_cyc  [$];
    logic          r_stall = 1'b0;
    logic [DW-1:0] r_stall_data = '0;

    always @(negedge clk) begin
        if (r_stall && rst_nm) begin
            check("hold_valid", 64'(m_tvalid), 64'd1);
            check("hold_data", 64'(m_tdata), 64'(r_stall_data));
        end
        r_stall      <= m_tvalid & !m_tready;
        r_stall_data <= m_tdata;
        if (m_tvalid && m_tready) begin
            cap_data.push_back(m_tdata);
            cap_last.push_back(m_tlast);
            cap_keep.push_back(m_tkeep);
            cap_user.push_back(m_tuser);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic cap_clear();
        cap_data.delete(); cap_last.delete(); cap_keep.delete(); cap_user.delete(); cap_cyc.delete();
    endtask

    function automatic logic [DW-1:0] mk(input int s, input int tag, input int b);
        return {8'(s), 24'(tag), 32'(b)};
    endfunction

    // Present one beat and wait (bounded) until the arbiter accepts it.
    task automatic drive_beat(input int s, input logic [DW-1:0] d, input logic sop, input logic eop);
        logic got;
        s_tvalid[s] = 1'b1; s_sop[s] = sop; s_eop[s] = eop; s_tdata[s] = d;
        s_tkeep[s] = KW'(d[7:0]);
        s_tuser[s] = TW'({4'hA, d[3:0]});
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tr[s]) begin got = 1'b1; break; end
        end
        check($sformatf("accept_src%0d", s), 64'(got), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drive_pkt(input int s, input int n, input int tag, input int mid);
        for (int b = 0; b < n; b++)
            drive_beat(s, mk(s, tag, b), (b == 0) || (b == mid), b == n - 1);
        s_tvalid[s] = 1'b0; s_sop[s] = 1'b0; s_eop[s] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    bit bp_done;
    int t0;
    int expo [6] = '{0, 1, 2, 0, 1, 2};
    int k;

    initial begin
        rst_nm = 1'b0; m_tready = 1'b1; err_clr = 1'b0;
        for (int s = 0; s < 3; s++) begin
            s_tvalid[s] = 1'b0; s_sop[s] = 1'b0; s_eop[s] = 1'b0;
            s_tdata[s] = '0; s_tkeep[s] = '0; s_tuser[s] = '0;
        end
        idle(3);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tready", 64'(tr), 64'd0);
        check("rst_cnts", {16'(sd_cnt), 16'(rc_cnt), 16'(rg_cnt)}, 64'd0);
        check("rst_errs", {err_nosop, err_midsop}, 64'd0);
        rst_nm = 1'b1;
        idle(2);

        // Round-robin fairness: all three keep requesting 2-beat packets.
        cap_clear();
        fork
            begin drive_pkt(0, 2, 0, -1); drive_pkt(0, 2, 1, -1); end
            begin drive_pkt(1, 2, 0, -1); drive_pkt(1, 2, 1, -1); end
            begin drive_pkt(2, 2, 0, -1); drive_pkt(2, 2, 1, -1); end
        join
        idle(3);
        check("rr_beats", cap_data.size(), 64'd12);
        k = 0;
        for (int i = 0; i < cap_data.size(); i++)
            if (cap_last[i]) begin
                if (k < 6) check($sformatf("rr_order%0d", k), 64'(cap_data[i][63:56]), 64'(expo[k]));
                k++;
            end
        check("rr_pkts", k, 64'd6);
        check("rr_cnts", {16'(sd_cnt), 16'(rc_cnt), 16'(rg_cnt)}, {16'd2, 16'd2, 16'd2});

        // Single source, 4 beats, ready held high.
        cap_clear();
        t0 = cyc;
        drive_pkt(0, 4, 7, -1);
        idle(3);
        check("single_beats", cap_data.size(), 64'd4);
        if (cap_data.size() == 4) begin
            check("single_latency", cap_cyc[0] - t0, 64'd3);
            check("single_back2back", cap_cyc[3] - cap_cyc[0], 64'd3);
            for (int b = 0; b < 4; b++) begin
                check($sformatf("single_data%0d", b), 64'(cap_data[b]), 64'(mk(0, 7, b)));
                check($sformatf("single_last%0d", b), 64'(cap_last[b]), 64'(b == 3));
                check($sformatf("single_user%0d", b), 64'(cap_user[b]), 64'(b));
                check($sformatf("single_keep%0d", b), 64'(cap_keep[b]), 64'(b));
            end
        end
        check("single_sd_cnt", 64'(sd_cnt), 64'd3);

        // Backpressure: m_tready toggles every cycle during an 8-beat rc packet.
        cap_clear();
        bp_done = 1'b0;
        fork
            begin drive_pkt(1, 8, 3, -1); bp_done = 1'b1; end
            begin
                for (int c = 0; c < 200 && !bp_done; c++) begin
                    m_tready = ~m_tready;
                    @(posedge clk); #1;
                end
                m_tready = 1'b1;
            end
        join
        idle(4);
        check("bp_beats", cap_data.size(), 64'd8);
        if (cap_data.size() == 8) begin
            for (int b = 0; b < 8; b++)
                check($sformatf("bp_data%0d", b), 64'(cap_data[b]), 64'(mk(1, 3, b)));
            check("bp_last", 64'(cap_last[7]), 64'd1);
        end
        check("bp_rc_cnt", 64'(rc_cnt), 64'd3);

        // No-sop flush from rg while idle.
        cap_clear();
        s_tvalid[2] = 1'b1; s_sop[2] = 1'b0; s_eop[2] = 1'b0; s_tdata[2] = mk(2, 9, 0);
        @(negedge clk);
        check("flush_tready", 64'(tr), 64'b100);
        @(posedge clk); #1;
        s_tvalid[2] = 1'b0;
        check("flush_err", 64'(err_nosop), 64'b100);
        idle(3);
        check("flush_no_output", cap_data.size(), 64'd0);
        check("flush_rg_cnt", 64'(rg_cnt), 64'd2);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("flush_clr", 64'(err_nosop), 64'd0);

        // Mid-packet sop on beat 2 of 3 from sd.
        cap_clear();
        drive_pkt(0, 3, 5, 1);
        idle(3);
        check("midsop_beats", cap_data.size(), 64'd3);
        if (cap_data.size() == 3)
            check("midsop_data1", 64'(cap_data[1]), 64'(mk(0, 5, 1)));
        check("midsop_err", 64'(err_midsop), 64'b001);
        check("midsop_sd_cnt", 64'(sd_cnt), 64'd4);

        // Reset while beat 2 of a 4-beat sd packet sits in the output register.
        drive_beat(0, mk(0, 6, 0), 1'b1, 1'b0);
        drive_beat(0, mk(0, 6, 1), 1'b0, 1'b0);
        check("prerst_tvalid", 64'(m_tvalid), 64'd1);
        rst_nm = 1'b0;
        s_tvalid[0] = 1'b0; s_sop[0] = 1'b0; s_eop[0] = 1'b0;
        idle(1);
        check("midrst_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_cnts", {16'(sd_cnt), 16'(rc_cnt), 16'(rg_cnt), 16'(u2_rc_cnt)}, 64'd0);
        check("midrst_errs", {err_nosop, err_midsop}, 64'd0);
        rst_nm = 1'b1;
        idle(1);

        // After reset sd must win against rc; then rc totals 5 packets (wraps to 1 at CNT_W=2).
        cap_clear();
        fork
            drive_pkt(1, 1, 10, -1);
            drive_pkt(0, 1, 11, -1);
        join
        idle(3);
        check("postrst_beats", cap_data.size(), 64'd2);
        if (cap_data.size() == 2) begin
            check("postrst_first_sd", 64'(cap_data[0]), 64'(mk(0, 11, 0)));
            check("postrst_then_rc", 64'(cap_data[1]), 64'(mk(1, 10, 0)));
        end
        for (int p = 0; p < 4; p++) drive_pkt(1, 1, 20 + p, -1);
        idle(3);
        check("wrap_rc_cnt16", 64'(rc_cnt), 64'd5);
        check("wrap_rc_cnt2", 64'(u2_rc_cnt), 64'd1);
        check("wrap_sd_cnt", 64'(sd_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/egress_tx_arbiter.md
# egress_tx_arbiter

Packet-level round-robin arbiter that shares the single PCIe IP TX AXIS port (`m_axis_tx_*`) between the three action modules: send (sd), receive (rc) and register (rg). Each requester presents sop/eop-framed beats. The arbiter locks onto one source for a whole packet, maps it to the Xilinx TX AXIS format through a one-deep pipeline register, and keeps per-source packet counters and sticky protocol-error flags. It sits between the action modules and the PCIe core, alongside `ingress_top`.

## Interface
Parameters:
- `CNT_W`, default 16: width of each per-source packet counter.

Ports:
- `clk`, in, 1: system clock.
- `` `rst_nm ``, in, 1: reset. Synchronous, active-low.
- `{sd,rc,rg}_s_axis_tx_tvalid`, in, 1: source beat valid.
- `{sd,rc,rg}_s_axis_tx_tready`, out, 1: source beat accepted.
- `{sd,rc,rg}_s_axis_tx_tdata`, in, `` `PCIE_DATA_WIDTH ``: payload.
- `{sd,rc,rg}_s_axis_tx_tkeep`, in, `` `PCIE_DATA_KW ``: byte enables.
- `{sd,rc,rg}_s_axis_tx_sop`, in, 1: first beat of the packet.
- `{sd,rc,rg}_s_axis_tx_eop`, in, 1: last beat of the packet.
- `{sd,rc,rg}_s_axis_tx_tuser`, in, `` `PCIE_TUSER_W ``: sideband. Must satisfy `` `PCIE_TUSER_W `` ≥ `` `XIL_TX_USER_W ``.
- `m_axis_tx_tready`, in, 1: PCIe core ready.
- `m_axis_tx_tvalid`, out, 1: output beat valid.
- `m_axis_tx_tdata`, out, `` `PCIE_DATA_WIDTH ``: output payload.
- `m_axis_tx_tkeep`, out, `` `PCIE_DATA_KW ``: output byte enables.
- `m_axis_tx_tlast`, out, 1: last beat (the registered `eop`).
- `m_axis_tx_tuser`, out, `` `XIL_TX_USER_W ``: low bits of the source `tuser`.
- `{sd,rc,rg}_pkt_cnt`, out, `CNT_W`: packets forwarded per source. Wraps.
- `err_nosop`, out, 3: sticky flag per source. A beat arrived outside a packet without `sop`. Bit order is [0]=sd, [1]=rc, [2]=rg.
- `err_midsop`, out, 3: sticky flag per source. `sop` was seen inside an open packet.
- `err_clr`, in, 1: synchronous clear of both error vectors.

## Operation
- **States:** IDLE, ARB, BUSY.
- **IDLE**
  - Request vector is `req[i] = tvalid[i] & sop[i]`.
  - If any `req[i]` is set: register `grant` using round-robin order, searching from `last+1` modulo 3. Go to ARB.
  - Any source with `tvalid & !sop` has its beat flushed: `tready=1`, data discarded, `err_nosop[i]` set. This happens in the same cycle.
- **ARB:** always transition to BUSY. This state exists only to break the timing path from the request vector into the grant register.
- **BUSY**
  - `tready[grant] = pipe_ready`, where `pipe_ready = !m_axis_tx_tvalid | m_axis_tx_tready`. All other `tready` outputs are 0.
  - Each accepted beat loads the output register: tdata, tkeep, `tlast=eop`, `tuser[`XIL_TX_USER_W-1:0]`.
  - Accepted beat with `sop` that is not the first beat of the packet: forward it unchanged and set `err_midsop[grant]`.
  - Accepted beat with `eop`: increment `pkt_cnt[grant]`, set `last=grant`, go to IDLE.
  - A single-beat packet (`sop & eop`) is legal.
- `m_axis_tx_tvalid` clears when `m_axis_tx_tready` is high and no new beat is loaded.
- `err_clr` takes precedence over a set in the same cycle.

## Timing
- **Reset values:**
  - All outputs are 0, and every `tready` is 0.
  - State is IDLE.
  - `last` = 2, so sd wins the first arbitration.
- **Latency:**
  - A `sop` presented in IDLE is accepted 2 cycles later (IDLE, then ARB, then acceptance in BUSY).
  - `m_axis_tx_tvalid` rises 1 cycle after acceptance.
- **Throughput:** one beat per clock inside a packet when `m_axis_tx_tready` stays high.
- **Packet gap:** 2 idle cycles on the source side between packets.
- **Backpressure:** `m_axis_tx_tready` low holds the output register stable (AXIS rule). `tready[grant]` drops combinationally in the same cycle.
- A source that drops `tvalid` mid-packet stalls the arbiter indefinitely. There is no timeout.
- **Counters** wrap from 2^CNT_W−1 to 0.
- **Reset mid-packet:** on the next edge the output register is cleared and state returns to IDLE. The partial packet is abandoned.

## Structure
- Shared package `pcie_pkg` holds:
  - source index constants `SRC_SD=0`, `SRC_RC=1`, `SRC_RG=2`, `NUM_SRC=3`;
  - the state enum `arb_state_e`;
  - a packed struct `tx_beat_t` containing data, keep, eop and tuser.
- One sub-module, `axis_pipe_reg`, implements the one-deep valid/ready output register using `tx_beat_t`.
- The round-robin selection is a function inside the package.

## Test plan
- **Single source:** sd sends a 4-beat packet (`sop` on beat 0, `eop` on beat 3), `m_axis_tx_tready=1`.
  - Required: 4 consecutive output beats; `tlast` only on beat 4; `sd_pkt_cnt=1`; first beat appears 3 cycles after the `sop` presentation.
- **Round-robin fairness:** all three sources continuously request 2-beat packets.
  - Required: grant order sd, rc, rg, sd, rc, rg. After 6 packets each counter equals 2.
- **Backpressure:** toggle `m_axis_tx_tready` 1/0 every cycle during an 8-beat rc packet.
  - Required: all 8 beats delivered in order; output held stable while not ready; no beat duplicated or lost.
- **No-sop flush:** in IDLE, rg presents `tvalid=1`, `sop=0`.
  - Required: rg `tready=1` that cycle; nothing appears on the output; `err_nosop=3'b100`; `err_clr` returns it to 0.
- **Mid-packet sop:** sd packet whose beat 2 of 3 also asserts `sop`.
  - Required: all 3 beats forwarded; `err_midsop=3'b001`; `sd_pkt_cnt` increments by 1.
- **Reset mid-packet, then counter wrap:**
  - Assert reset while beat 2 of a 4-beat packet is in the output register. Required: `m_axis_tx_tvalid=0` on the next cycle, all counters 0, sd wins the next arbitration.
  - Separately, with `CNT_W=2`, send 5 packets from rc. Required: `rc_pkt_cnt=1`.
